cms_heap_drain: RTL and testbench

//  Downstream stage of cms_heap: on a start command, pops up to N {key,value} entries from the heap read

---
 rtl/cms_pkg.sv | 21 ++
 rtl/cms_drain_skid.sv | 98 +++++++++
 rtl/cms_heap_drain.sv | 146 ++++++++++++++
 tb/tb_cms_heap_drain.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cms_pkg.sv
// rtl/cms_pkg.sv - shared count-min-sketch constants, key/value entry and drain state types
package cms_pkg;

  localparam int CMS_HEAP_DEPTH  = 256;
  localparam int CMS_KEY_WIDTH   = 32;
  localparam int CMS_VALUE_WIDTH = 32;
  localparam int CMS_TIMEOUT     = 16;

  typedef struct packed {
    logic [CMS_KEY_WIDTH-1:0]   key;
    logic [CMS_VALUE_WIDTH-1:0] value;
  } kv_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } drain_state_t;

endpackage

// File: rtl/cms_drain_skid.sv
// rtl/cms_drain_skid.sv - hold register plus output register; the held entry is tagged last on flush
module cms_drain_skid #(
  parameter int KW = 32,
  parameter int VW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [KW-1:0] push_key,
  input  logic [VW-1:0] push_value,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [KW-1:0] out_key,
  output logic [VW-1:0] out_value,
  output logic          out_last,
  output logic          full,
  output logic          empty
);

  logic          hold_valid_q, hold_valid_d;
  logic [KW-1:0] hold_key_q, hold_key_d;
  logic [VW-1:0] hold_value_q, hold_value_d;
  logic          out_valid_q, out_valid_d;
  logic [KW-1:0] out_key_q, out_key_d;
  logic [VW-1:0] out_value_q, out_value_d;
  logic          out_last_q, out_last_d;
  logic          out_free;

  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_key_d   = hold_key_q;
    hold_value_d = hold_value_q;
    out_valid_d  = out_valid_q;
    out_key_d    = out_key_q;
    out_value_d  = out_value_q;
    out_last_d   = out_last_q;
    if (clear) begin
      hold_valid_d = 1'b0;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
      // A push only happens when the output register is empty if hold is occupied
      if (push) begin
        if (hold_valid_q) begin
          out_valid_d = 1'b1;
          out_key_d   = hold_key_q;
          out_value_d = hold_value_q;
          out_last_d  = 1'b0;
        end
        hold_valid_d = 1'b1;
        hold_key_d   = push_key;
        hold_value_d = push_value;
      end else if (flush && hold_valid_q && out_free) begin
        out_valid_d  = 1'b1;
        out_key_d    = hold_key_q;
        out_value_d  = hold_value_q;
        out_last_d   = 1'b1;
        hold_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_key_q   <= '0;
      hold_value_q <= '0;
      out_valid_q  <= 1'b0;
      out_key_q    <= '0;
      out_value_q  <= '0;
      out_last_q   <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_key_q   <= hold_key_d;
      hold_value_q <= hold_value_d;
      out_valid_q  <= out_valid_d;
      out_key_q    <= out_key_d;
      out_value_q  <= out_value_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_key   = out_key_q;
  assign out_value = out_value_q;
  assign out_last  = out_last_q;
  assign full      = hold_valid_q && out_valid_q;
  assign empty     = !hold_valid_q && !out_valid_q;

endmodule

// File: rtl/cms_heap_drain.sv
// rtl/cms_heap_drain.sv - pops up to N heap entries, filters by threshold, streams them out with last
module cms_heap_drain
  import cms_pkg::*;
#(
  parameter int  HEAP_DEPTH  = CMS_HEAP_DEPTH,
  parameter int  KEY_WIDTH   = CMS_KEY_WIDTH,
  parameter int  VALUE_WIDTH = CMS_VALUE_WIDTH,
  parameter int  TIMEOUT     = CMS_TIMEOUT,
  localparam int CNT_W       = $clog2(HEAP_DEPTH + 1)
) (
  input  logic                   ap_clk,
  input  logic                   ap_reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       count,
  input  logic [VALUE_WIDTH-1:0] threshold,
  input  logic                   abort,
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic                   kv_in_valid,
  output logic                   kv_in_ready,
  output logic [KEY_WIDTH-1:0]   out_key,
  output logic [VALUE_WIDTH-1:0] out_value,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [CNT_W-1:0]       fwd_count
);

  localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(HEAP_DEPTH);
  localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT);

  drain_state_t           state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [VALUE_WIDTH-1:0] thr_q, thr_d;
  logic [CNT_W-1:0]       popped_q, popped_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic [CNT_W-1:0]       fwd_q, fwd_d;
  logic                   aborted_q, aborted_d;
  logic                   active, pop, fwd, skid_full, skid_empty;

  assign active      = (state_q == ST_DRAIN) || (state_q == ST_FLUSH);
  // Ready depends only on registered state; both slots full stalls the heap
  assign kv_in_ready = (state_q == ST_DRAIN) && !skid_full;
  assign pop         = kv_in_valid && kv_in_ready;
  assign fwd         = pop && !abort && (value_in >= thr_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    thr_d     = thr_q;
    popped_d  = popped_q;
    idle_d    = idle_q;
    fwd_d     = fwd_q;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d   = (count > DEPTH_C) ? DEPTH_C : count;
          thr_d     = threshold;
          popped_d  = '0;
          idle_d    = '0;
          fwd_d     = '0;
          aborted_d = 1'b0;
          state_d   = (count == '0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          if (pop) begin
            popped_d = (popped_q != DEPTH_C) ? popped_q + 1'b1 : popped_q;
            idle_d   = '0;
            if (fwd) fwd_d = (fwd_q != DEPTH_C) ? fwd_q + 1'b1 : fwd_q;
          end else if (kv_in_valid) begin
            idle_d = '0;
          end else if (idle_q != TIMEOUT_C) begin
            idle_d = idle_q + 1'b1;
          end
          if ((popped_d == count_q) || (idle_d == TIMEOUT_C)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (skid_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_reset) begin
    if (ap_reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      thr_q     <= '0;
      popped_q  <= '0;
      idle_q    <= '0;
      fwd_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      thr_q     <= thr_d;
      popped_q  <= popped_d;
      idle_q    <= idle_d;
      fwd_q     <= fwd_d;
      aborted_q <= aborted_d;
    end
  end

  cms_drain_skid #(
    .KW(KEY_WIDTH),
    .VW(VALUE_WIDTH)
  ) u_skid (
    .clk       (ap_clk),
    .rst       (ap_reset),
    .clear     (abort && active),
    .push      (fwd),
    .push_key  (key_in),
    .push_value(value_in),
    .flush     (state_q == ST_FLUSH),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_key   (out_key),
    .out_value (out_value),
    .out_last  (out_last),
    .full      (skid_full),
    .empty     (skid_empty)
  );

  assign busy      = active;
  assign done      = (state_q == ST_DONE);
  assign aborted   = aborted_q;
  assign fwd_count = fwd_q;

endmodule

// File: tb/tb_cms_heap_drain.sv
// tb/tb_cms_heap_drain.sv - vector table plus scoreboard bench for cms_heap_drain
module tb_cms_heap_drain;
  import cms_pkg::*;

  localparam int CNT_W = $clog2(CMS_HEAP_DEPTH + 1);

  logic              ap_clk, ap_reset;
  logic              start, abort, kv_in_valid, kv_in_ready, out_ready;
  logic [CNT_W-1:0]  count, fwd_count;
  logic [31:0]       threshold, key_in, value_in, out_key, out_value;
  logic              out_last, out_valid, busy, done, aborted;

  cms_heap_drain dut (
    .ap_clk(ap_clk), .ap_reset(ap_reset), .start(start), .count(count),
    .threshold(threshold), .abort(abort), .key_in(key_in), .value_in(value_in),
    .kv_in_valid(kv_in_valid), .kv_in_ready(kv_in_ready), .out_key(out_key),
    .out_value(out_value), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .aborted(aborted),
    .fwd_count(fwd_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int               cnt;
    int               thr;
    int               nent;
    bit               gen;
    logic [0:7][15:0] vals;
    int               stall;
    int               exp_pops;
    int               exp_fwd;
    int               exp_stall_pops;
  } vec_t;

  kv_t heap_q[$];
  kv_t exp_q[$];

  function automatic logic [0:7][15:0] pk8(input int a, b, c, d, e, f, g, h);
    return {16'(a), 16'(b), 16'(c), 16'(d), 16'(e), 16'(f), 16'(g), 16'(h)};
  endfunction

  function automatic vec_t mkv(input int cnt, thr, nent, input bit gen, input logic [0:7][15:0] vals,
                               input int stall, exp_pops, exp_fwd, exp_stall_pops);
    vec_t v;
    v.cnt = cnt; v.thr = thr; v.nent = nent; v.gen = gen; v.vals = vals; v.stall = stall;
    v.exp_pops = exp_pops; v.exp_fwd = exp_fwd; v.exp_stall_pops = exp_stall_pops;
    return v;
  endfunction

  task automatic drive_heap();
    kv_in_valid = (heap_q.size() > 0);
    if (kv_in_valid) begin
      key_in   = heap_q[0].key;
      value_in = heap_q[0].value;
    end
  endtask

  task automatic run_vec(input vec_t v, input int vid);
    kv_t e;
    int  pops, outs, nlast, stall_pops;
    bit  fin, final_last;
    logic [CNT_W-1:0] fc;
    logic ab, bz;
    heap_q.delete();
    exp_q.delete();
    for (int i = 0; i < v.nent; i++) begin
      e.key   = {8'(vid), 24'(i)};
      e.value = v.gen ? 32'(i + 1) : 32'(v.vals[i]);
      heap_q.push_back(e);
    end
    pops = 0; outs = 0; nlast = 0; stall_pops = 0; fin = 0; final_last = 0;
    fc = '0; ab = 1'b0; bz = 1'b0;
    @(negedge ap_clk);
    start = 1'b1; count = CNT_W'(v.cnt); threshold = 32'(v.thr); kv_in_valid = 1'b0;
    for (int c = 0; c < 6000 && !fin; c++) begin
      @(negedge ap_clk);
      start     = 1'b0;
      out_ready = (c >= v.stall);
      drive_heap();
      if (kv_in_valid && kv_in_ready) begin
        e = heap_q.pop_front();
        pops++;
        if (e.value >= 32'(v.thr)) exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        outs++;
        nlast += int'(out_last);
        final_last = out_last;
        if (exp_q.size() == 0) begin
          chk($sformatf("v%0d_extra_output", vid), 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("v%0d_out_key", vid), out_key, e.key);
          chk($sformatf("v%0d_out_value", vid), out_value, e.value);
        end
      end
      if (c == v.stall - 1) stall_pops = pops;
      if (done) begin
        fin = 1; fc = fwd_count; ab = aborted; bz = busy;
      end
    end
    kv_in_valid = 1'b0;
    out_ready   = 1'b1;
    chk($sformatf("v%0d_done_seen", vid), fin, 1);
    chk($sformatf("v%0d_pops", vid), pops, v.exp_pops);
    chk($sformatf("v%0d_outputs", vid), outs, v.exp_fwd);
    chk($sformatf("v%0d_fwd_count", vid), fc, v.exp_fwd);
    chk($sformatf("v%0d_aborted", vid), ab, 0);
    chk($sformatf("v%0d_busy_at_done", vid), bz, 0);
    chk($sformatf("v%0d_last_count", vid), nlast, (v.exp_fwd > 0) ? 1 : 0);
    chk($sformatf("v%0d_scoreboard_empty", vid), exp_q.size(), 0);
    if (v.exp_fwd > 0) chk($sformatf("v%0d_final_last", vid), final_last, 1);
    if (v.stall > 0) chk($sformatf("v%0d_stall_pops", vid), stall_pops, v.exp_stall_pops);
  endtask

  vec_t vt[7];
  kv_t  ent;

  initial begin
    vt[0] = mkv(4,    0,   4,   0, pk8(1, 2, 3, 4, 0, 0, 0, 0),          0,  4,   4,   0);
    vt[1] = mkv(6,    100, 6,   0, pk8(50, 200, 99, 100, 300, 10, 0, 0), 0,  6,   3,   0);
    vt[2] = mkv(8,    0,   3,   0, pk8(7, 8, 9, 0, 0, 0, 0, 0),          0,  3,   3,   0);
    vt[3] = mkv(5,    0,   5,   0, pk8(11, 12, 13, 14, 15, 0, 0, 0),     20, 5,   5,   2);
    vt[4] = mkv(0,    0,   4,   0, pk8(1, 2, 3, 4, 0, 0, 0, 0),          0,  0,   0,   0);
    vt[5] = mkv(500,  0,   300, 1, pk8(0, 0, 0, 0, 0, 0, 0, 0),          0,  256, 256, 0);
    vt[6] = mkv(3,    1000, 3,  0, pk8(5, 6, 7, 0, 0, 0, 0, 0),          0,  3,   0,   0);

    ap_reset = 1'b1; start = 1'b0; abort = 1'b0; count = '0; threshold = '0;
    key_in = '0; value_in = '0; kv_in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge ap_clk);
    chk("rst_kv_in_ready", kv_in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_out_key", out_key, 0);
    chk("rst_fwd_count", fwd_count, 0);
    ap_reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // abort while both slots are full and the output is stalled
    heap_q.delete();
    for (int i = 0; i < 5; i++) begin
      ent.key = 32'hC000 + 32'(i); ent.value = 32'(i + 10); heap_q.push_back(ent);
    end
    @(negedge ap_clk);
    start = 1'b1; count = CNT_W'(5); threshold = '0; out_ready = 1'b0;
    begin
      bit stalled = 0;
      for (int c = 0; c < 50 && !stalled; c++) begin
        @(negedge ap_clk);
        start = 1'b0;
        drive_heap();
        if (kv_in_valid && kv_in_ready) void'(heap_q.pop_front());
        stalled = out_valid && !kv_in_ready;
      end
      chk("abort_stall_reached", stalled, 1);
    end
    abort = 1'b1;
    @(negedge ap_clk);
    abort = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_done", done, 1);
    chk("abort_aborted", aborted, 1);
    chk("abort_busy", busy, 0);
    chk("abort_fwd_count", fwd_count, 2);
    @(negedge ap_clk);
    chk("abort_done_pulse", done, 0);
    chk("abort_held", aborted, 1);
    abort = 1'b1;
    @(negedge ap_clk);
    abort = 1'b0;
    chk("abort_idle_ignored", done, 0);

    // start during DONE is ignored; a new start clears aborted
    kv_in_valid = 1'b0; out_ready = 1'b1;
    start = 1'b1; count = '0;
    @(negedge ap_clk);
    chk("zero_done", done, 1);
    chk("zero_clears_aborted", aborted, 0);
    count = CNT_W'(3);
    @(negedge ap_clk);
    start = 1'b0;
    chk("done_single_pulse", done, 0);
    @(negedge ap_clk);
    chk("start_in_done_ignored", busy, 0);

    // asynchronous reset in the middle of a stalled drain
    heap_q.delete();
    for (int i = 0; i < 5; i++) begin
      ent.key = 32'hD000 + 32'(i); ent.value = 32'(i + 1); heap_q.push_back(ent);
    end
    start = 1'b1; count = CNT_W'(5); out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge ap_clk);
      start = 1'b0;
      drive_heap();
      if (kv_in_valid && kv_in_ready) void'(heap_q.pop_front());
    end
    chk("pre_reset_out_valid", out_valid, 1);
    ap_reset = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_kv_in_ready", kv_in_ready, 0);
    chk("async_rst_fwd_count", fwd_count, 0);
    @(negedge ap_clk);
    ap_reset = 1'b0; kv_in_valid = 1'b0; out_ready = 1'b1;
    @(negedge ap_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
